dp_ram_arb: RTL

Single-clock arbiter sharing one dual-port RAM between two clients (0 and 1). The write port and the read port each have an independent round-robin arbiter. Granted commands are registered before they are driven to the RAM. Read data is routed back to the requesting client with a valid strobe, and a same-address write/read collision is resolved by holding the read.

---
 rtl/dp_ram_arb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dp_ram_arb.sv
// rtl/dp_ram_arb.sv - two-client round-robin arbiter in front of a dual-port RAM
module dp_ram_arb #(
   parameter int data_width = 4,
   parameter int addr_width = 4,
   parameter int rd_lat     = 1
) (
   input  logic                  clk_dp_ram_arb,
   input  logic                  rst_dp_ram_arb,
   // client write side
   input  logic                  wt_req_0,
   input  logic                  wt_req_1,
   input  logic [addr_width-1:0] wt_addr_0,
   input  logic [addr_width-1:0] wt_addr_1,
   input  logic [data_width-1:0] wt_data_0,
   input  logic [data_width-1:0] wt_data_1,
   output logic                  wt_gnt_0,
   output logic                  wt_gnt_1,
   // client read side
   input  logic                  rd_req_0,
   input  logic                  rd_req_1,
   input  logic [addr_width-1:0] rd_addr_0,
   input  logic [addr_width-1:0] rd_addr_1,
   output logic                  rd_gnt_0,
   output logic                  rd_gnt_1,
   output logic [data_width-1:0] rd_data_0,
   output logic [data_width-1:0] rd_data_1,
   output logic                  rd_valid_0,
   output logic                  rd_valid_1,
   // RAM side
   output logic                  wt_en_dp_ram,
   output logic [addr_width-1:0] wt_addr,
   output logic [data_width-1:0] data_in_dp_ram,
   output logic                  rd_en_dp_ram,
   output logic [addr_width-1:0] rd_addr,
   input  logic [data_width-1:0] data_out_dp_ram
);

   // One tag stage per cycle between grant and return: command register
   // stage plus rd_lat RAM cycles.
   localparam int tag_depth = rd_lat + 1;

   // Priority pointers: 0 means client 0 wins a tie, 1 means client 1 wins.
   logic                  r_wt_pri;
   logic                  r_rd_pri;

   logic                  w_wt_gnt_0;
   logic                  w_wt_gnt_1;
   logic                  w_wt_any;
   logic [addr_width-1:0] w_wt_addr_sel;
   logic [data_width-1:0] w_wt_data_sel;

   logic                  w_rd_cand_0;
   logic                  w_rd_cand_1;
   logic                  w_rd_cand_any;
   logic [addr_width-1:0] w_rd_addr_sel;
   logic                  w_rd_collide;
   logic                  w_rd_gnt_0;
   logic                  w_rd_gnt_1;
   logic                  w_rd_any;

   logic                  r_wt_en;
   logic [addr_width-1:0] r_wt_addr;
   logic [data_width-1:0] r_wt_data;
   logic                  r_rd_en;
   logic [addr_width-1:0] r_rd_addr;

   // Tag pipeline: valid bit and requesting client id per in-flight read.
   logic [tag_depth-1:0]  r_tag_v;
   logic [tag_depth-1:0]  r_tag_id;

   logic                  w_ret_0;
   logic                  w_ret_1;
   logic [data_width-1:0] r_rd_data_0;
   logic [data_width-1:0] r_rd_data_1;

   // Write arbiter: a lone requester wins, a tie goes to the priority client.
   always_comb begin
      w_wt_gnt_0    = wt_req_0 & (~wt_req_1 | ~r_wt_pri);
      w_wt_gnt_1    = wt_req_1 & (~wt_req_0 |  r_wt_pri);
      w_wt_any      = w_wt_gnt_0 | w_wt_gnt_1;
      w_wt_addr_sel = w_wt_gnt_1 ? wt_addr_1 : wt_addr_0;
      w_wt_data_sel = w_wt_gnt_1 ? wt_data_1 : wt_data_0;
   end

   // Read arbiter: same rules, then a read that hits the address being
   // written this cycle is held back so its retry sees the new data.
   always_comb begin
      w_rd_cand_0   = rd_req_0 & (~rd_req_1 | ~r_rd_pri);
      w_rd_cand_1   = rd_req_1 & (~rd_req_0 |  r_rd_pri);
      w_rd_cand_any = w_rd_cand_0 | w_rd_cand_1;
      w_rd_addr_sel = w_rd_cand_1 ? rd_addr_1 : rd_addr_0;
      w_rd_collide  = w_wt_any & w_rd_cand_any & (w_rd_addr_sel == w_wt_addr_sel);
      w_rd_gnt_0    = w_rd_cand_0 & ~w_rd_collide;
      w_rd_gnt_1    = w_rd_cand_1 & ~w_rd_collide;
      w_rd_any      = w_rd_gnt_0 | w_rd_gnt_1;
   end

   assign wt_gnt_0 = w_wt_gnt_0;
   assign wt_gnt_1 = w_wt_gnt_1;
   assign rd_gnt_0 = w_rd_gnt_0;
   assign rd_gnt_1 = w_rd_gnt_1;

   // Priority pointers flip to the other client after each grant; a held
   // (collided) read leaves the read pointer where it was.
   always_ff @(posedge clk_dp_ram_arb or posedge rst_dp_ram_arb) begin
      if (rst_dp_ram_arb) begin
         r_wt_pri <= 1'b0;
         r_rd_pri <= 1'b0;
      end else begin
         if (w_wt_any) begin
            r_wt_pri <= w_wt_gnt_0;
         end
         if (w_rd_any) begin
            r_rd_pri <= w_rd_gnt_0;
         end
      end
   end

   // Command register: enables pulse one cycle per grant, address and data
   // hold their last values while idle.
   always_ff @(posedge clk_dp_ram_arb or posedge rst_dp_ram_arb) begin
      if (rst_dp_ram_arb) begin
         r_wt_en   <= 1'b0;
         r_wt_addr <= '0;
         r_wt_data <= '0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
      end else begin
         r_wt_en <= w_wt_any;
         r_rd_en <= w_rd_any;
         if (w_wt_any) begin
            r_wt_addr <= w_wt_addr_sel;
            r_wt_data <= w_wt_data_sel;
         end
         if (w_rd_any) begin
            r_rd_addr <= w_rd_addr_sel;
         end
      end
   end

   assign wt_en_dp_ram   = r_wt_en;
   assign wt_addr        = r_wt_addr;
   assign data_in_dp_ram = r_wt_data;
   assign rd_en_dp_ram   = r_rd_en;
   assign rd_addr        = r_rd_addr;

   // Tag shift register: a tag enters on the grant edge and reaches the last
   // stage in the cycle the RAM presents that read's data.
   always_ff @(posedge clk_dp_ram_arb or posedge rst_dp_ram_arb) begin
      if (rst_dp_ram_arb) begin
         r_tag_v  <= '0;
         r_tag_id <= '0;
      end else begin
         r_tag_v  <= {r_tag_v[tag_depth-2:0],  w_rd_any};
         r_tag_id <= {r_tag_id[tag_depth-2:0], w_rd_gnt_1};
      end
   end

   assign w_ret_0 = r_tag_v[tag_depth-1] & ~r_tag_id[tag_depth-1];
   assign w_ret_1 = r_tag_v[tag_depth-1] &  r_tag_id[tag_depth-1];

   // Return capture: keep the last data delivered to each client so it stays
   // readable between returns.
   always_ff @(posedge clk_dp_ram_arb or posedge rst_dp_ram_arb) begin
      if (rst_dp_ram_arb) begin
         r_rd_data_0 <= '0;
         r_rd_data_1 <= '0;
      end else begin
         if (w_ret_0) begin
            r_rd_data_0 <= data_out_dp_ram;
         end
         if (w_ret_1) begin
            r_rd_data_1 <= data_out_dp_ram;
         end
      end
   end

   // During the return cycle the RAM data is passed straight through so the
   // strobe and data line up; otherwise the captured copy is shown.
   assign rd_valid_0 = w_ret_0;
   assign rd_valid_1 = w_ret_1;
   assign rd_data_0  = w_ret_0 ? data_out_dp_ram : r_rd_data_0;
   assign rd_data_1  = w_ret_1 ? data_out_dp_ram : r_rd_data_1;

endmodule
